// File: rtl/code_seq_pkg.sv
// Shared types and constants for the code sequence sender.
package code_seq_pkg;

  localparam int unsigned NUM_W   = 3;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned TIMER_W = 4;
  localparam int unsigned ATT_W   = 3;

  localparam logic [NUM_W-1:0] DEF_CODE0    = 3'b001;
  localparam logic [NUM_W-1:0] DEF_CODE1    = 3'b011;
  localparam logic [NUM_W-1:0] DEF_CODE2    = 3'b101;
  localparam logic [NUM_W-1:0] DEF_IDLE_VAL = 3'b000;

  localparam int unsigned DEF_TIMEOUT   = 4;
  localparam int unsigned DEF_MAX_RETRY = 2;

  localparam logic [ATT_W-1:0] ATT_MAX = 3'd7;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_SEND0 = 3'd1,
    ST_SEND1 = 3'd2,
    ST_SEND2 = 3'd3,
    ST_WAIT  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  // Saturating attempt increment.
  function automatic logic [ATT_W-1:0] att_inc(input logic [ATT_W-1:0] a);
    return (a == ATT_MAX) ? a : a + ATT_W'(1);
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Loadable down-counter used to bound the wait for the lock's unlocked flag.
module seq_wait_timer
  import code_seq_pkg::*;
#(
  parameter int unsigned W = TIMER_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         enable,
  output logic         expired_c
);

  logic [W-1:0] count;

  // Clear beats load beats decrement; the count parks at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (enable && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  // Final wait cycle is the one in which the count reads zero.
  assign expired_c = (count == '0);

endmodule

// File: rtl/code_sequence_sender.sv
// Drives the 3-digit unlock code onto the lock's number bus, then waits for
// the unlocked flag, retrying a bounded number of times before reporting fail.
module code_sequence_sender
  import code_seq_pkg::*;
#(
  parameter int unsigned      WIDTH     = NUM_W,
  parameter logic [WIDTH-1:0] CODE0     = WIDTH'(DEF_CODE0),
  parameter logic [WIDTH-1:0] CODE1     = WIDTH'(DEF_CODE1),
  parameter logic [WIDTH-1:0] CODE2     = WIDTH'(DEF_CODE2),
  parameter logic [WIDTH-1:0] IDLE_VAL  = WIDTH'(DEF_IDLE_VAL),
  parameter int unsigned      TIMEOUT   = DEF_TIMEOUT,
  parameter int unsigned      MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             unlocked_in,
  output logic [WIDTH-1:0] number,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [ATT_W-1:0] attempts
);

  // WAIT lasts exactly TIMEOUT cycles: loaded with TIMEOUT-1, expires at zero.
  localparam logic [TIMER_W-1:0] WAIT_LOAD  = TIMER_W'(TIMEOUT - 1);
  localparam logic [ATT_W-1:0]   RETRY_LIM  = ATT_W'(MAX_RETRY);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] number_nx;
  logic             busy_nx;
  logic             done_nx;
  logic             fail_nx;
  logic [ATT_W-1:0] attempts_nx;

  logic tmr_clear;
  logic tmr_load;
  logic tmr_en;
  logic tmr_expired;

  seq_wait_timer #(
    .W (TIMER_W)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (tmr_clear),
    .load      (tmr_load),
    .load_val  (WAIT_LOAD),
    .enable    (tmr_en),
    .expired_c (tmr_expired)
  );

  // State and all outputs registered together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      number   <= IDLE_VAL;
      busy     <= 1'b0;
      done     <= 1'b0;
      fail     <= 1'b0;
      attempts <= '0;
    end else begin
      state    <= state_nx;
      number   <= number_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      fail     <= fail_nx;
      attempts <= attempts_nx;
    end
  end

  // Next state, next outputs and timer control.
  always_comb begin
    state_nx    = state;
    done_nx     = 1'b0;
    fail_nx     = 1'b0;
    attempts_nx = attempts;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;
    tmr_clear   = 1'b0;
    number_nx   = IDLE_VAL;
    busy_nx     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          if (unlocked_in) begin
            done_nx     = 1'b1;
            attempts_nx = '0;
          end else begin
            state_nx    = ST_SEND0;
            attempts_nx = ATT_W'(1);
          end
        end
      end
      ST_SEND0: state_nx = ST_SEND1;
      ST_SEND1: state_nx = ST_SEND2;
      ST_SEND2: begin
        state_nx = ST_WAIT;
        tmr_load = 1'b1;
      end
      ST_WAIT: begin
        tmr_en = 1'b1;
        if (unlocked_in) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
        end else if (tmr_expired) begin
          if (attempts <= RETRY_LIM) begin
            state_nx = ST_GAP;
          end else begin
            state_nx = ST_IDLE;
            fail_nx  = 1'b1;
          end
        end
      end
      ST_GAP: begin
        state_nx    = ST_SEND0;
        attempts_nx = att_inc(attempts);
      end
      default: state_nx = ST_IDLE;
    endcase

    // Abort overrides everything, including a same-cycle unlock.
    if (abort && (state != ST_IDLE)) begin
      state_nx    = ST_IDLE;
      done_nx     = 1'b0;
      fail_nx     = 1'b1;
      attempts_nx = attempts;
      tmr_load    = 1'b0;
    end

    if ((state == ST_WAIT) && (state_nx != ST_WAIT)) begin
      tmr_clear = 1'b1;
    end

    case (state_nx)
      ST_SEND0: number_nx = CODE0;
      ST_SEND1: number_nx = CODE1;
      ST_SEND2: number_nx = CODE2;
      default:  number_nx = IDLE_VAL;
    endcase

    busy_nx = (state_nx != ST_IDLE);
  end

endmodule

// File: tb/tb_code_sequence_sender.sv
// Bench for code_sequence_sender: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a position-based reference model.
module tb_code_sequence_sender;

  localparam int unsigned T  = 4;
  localparam int unsigned MR = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic       unlocked_in;
  logic [2:0] number;
  logic       busy;
  logic       done;
  logic       fail;
  logic [2:0] attempts;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  code_sequence_sender #(
    .TIMEOUT   (T),
    .MAX_RETRY (MR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .unlocked_in (unlocked_in),
    .number      (number),
    .busy        (busy),
    .done        (done),
    .fail        (fail),
    .attempts    (attempts)
  );

  typedef struct {
    bit st;
    bit ab;
    bit ul;
    int num;
    bit bsy;
    bit dn;
    bit fl;
    int att;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input bit st, input bit ab, input bit ul, input int num,
                     input bit bsy, input bit dn, input bit fl, input int att);
    vec_t v;
    v.st = st; v.ab = ab; v.ul = ul; v.num = num;
    v.bsy = bsy; v.dn = dn; v.fl = fl; v.att = att;
    vq.push_back(v);
  endtask

  // Reference model: position within one attempt (0..2 digits, 3..3+T-1 wait,
  // 3+T gap) plus an attempt count.
  bit m_active;
  int m_pos;
  int m_att;
  int code_tab[3] = '{1, 3, 5};

  task automatic model_step(input bit st, input bit ab, input bit ul,
                            output int e_num, output bit e_busy,
                            output bit e_done, output bit e_fail);
    e_done = 1'b0;
    e_fail = 1'b0;
    if (!m_active) begin
      if (st) begin
        if (ul) begin
          e_done = 1'b1;
          m_att  = 0;
        end else begin
          m_active = 1'b1;
          m_pos    = 0;
          m_att    = 1;
        end
      end
    end else if (ab) begin
      m_active = 1'b0;
      e_fail   = 1'b1;
    end else if (m_pos >= 3 && m_pos < 3 + int'(T) && ul) begin
      m_active = 1'b0;
      e_done   = 1'b1;
    end else if (m_pos == 3 + int'(T) - 1) begin
      if (m_att <= int'(MR)) m_pos = m_pos + 1;
      else begin
        m_active = 1'b0;
        e_fail   = 1'b1;
      end
    end else if (m_pos == 3 + int'(T)) begin
      m_pos = 0;
      m_att = (m_att >= 7) ? 7 : m_att + 1;
    end else begin
      m_pos = m_pos + 1;
    end
    e_num  = (m_active && m_pos < 3) ? code_tab[m_pos] : 0;
    e_busy = m_active;
  endtask

  // Start with lock held so unlocked_in rises at cycle 5 (2 clocks after CODE2).
  task automatic send_and_check(input string tag, input bit poke);
    start = 1'b1; abort = 1'b0; unlocked_in = 1'b0;
    tick();
    start = 1'b0;
    chk($sformatf("%s.digit0", tag), int'(number), 1);
    chk($sformatf("%s.att", tag), int'(attempts), 1);
    chk($sformatf("%s.busy1", tag), int'(busy), 1);
    tick();
    chk($sformatf("%s.digit1", tag), int'(number), 3);
    tick();
    chk($sformatf("%s.digit2", tag), int'(number), 5);
    start = poke;
    tick();
    chk($sformatf("%s.wait0_num", tag), int'(number), 0);
    chk($sformatf("%s.wait0_busy", tag), int'(busy), 1);
    start = poke;
    tick();
    chk($sformatf("%s.wait1_num", tag), int'(number), 0);
    chk($sformatf("%s.wait1_done", tag), int'(done), 0);
    start = poke; unlocked_in = 1'b1;
    tick();
    chk($sformatf("%s.done", tag), int'(done), 1);
    chk($sformatf("%s.done_busy", tag), int'(busy), 0);
    chk($sformatf("%s.done_fail", tag), int'(fail), 0);
    chk($sformatf("%s.done_att", tag), int'(attempts), 1);
    start = 1'b0; unlocked_in = 1'b0;
    tick();
    chk($sformatf("%s.after_done", tag), int'(done), 0);
    chk($sformatf("%s.after_busy", tag), int'(busy), 0);
    chk($sformatf("%s.after_num", tag), int'(number), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int got[$];
    int exp_q[$];
    bit seen_fail;
    int cyc;
    int last_match;
    int p0, p1, p2;
    bit lock_on;

    start = 1'b0; abort = 1'b0; unlocked_in = 1'b0; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.number", int'(number), 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.done", int'(done), 0);
    chk("reset.fail", int'(fail), 0);
    chk("reset.attempts", int'(attempts), 0);
    reset = 1'b0;

    // st ab ul | num busy done fail att
    add(1, 0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 3, 1, 0, 0, 1);
    add(0, 0, 0, 5, 1, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 1);
    add(0, 0, 1, 0, 0, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 1);
    add(1, 0, 1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 3, 1, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 1, 3, 1, 0, 0, 1);
    add(0, 0, 1, 5, 1, 0, 0, 1);
    add(0, 0, 1, 0, 1, 0, 0, 1);
    add(0, 1, 1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);

    foreach (vq[i]) begin
      start = vq[i].st; abort = vq[i].ab; unlocked_in = vq[i].ul;
      tick();
      chk($sformatf("vec%0d.number", i), int'(number), vq[i].num);
      chk($sformatf("vec%0d.busy", i), int'(busy), int'(vq[i].bsy));
      chk($sformatf("vec%0d.done", i), int'(done), int'(vq[i].dn));
      chk($sformatf("vec%0d.fail", i), int'(fail), int'(vq[i].fl));
      chk($sformatf("vec%0d.attempts", i), int'(attempts), vq[i].att);
    end
    start = 1'b0; abort = 1'b0; unlocked_in = 1'b0;

    // Retry then fail: lock never answers.
    for (int a = 0; a <= int'(MR); a++) begin
      exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(5);
      for (int w = 0; w < int'(T); w++) exp_q.push_back(0);
      if (a < int'(MR)) exp_q.push_back(0);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    seen_fail = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (fail) begin
        seen_fail = 1'b1;
        break;
      end
      got.push_back(int'(number));
      chk("retry.no_done", int'(done), 0);
      chk("retry.busy", int'(busy), 1);
      tick();
    end
    chk("retry.fail_seen", int'(seen_fail), 1);
    chk("retry.length", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("retry.num%0d", i), got[i], exp_q[i]);
    chk("retry.attempts", int'(attempts), int'(MR) + 1);
    chk("retry.fail_busy", int'(busy), 0);
    chk("retry.fail_done", int'(done), 0);
    tick();
    chk("retry.fail_one_cycle", int'(fail), 0);

    // Asynchronous reset while waiting for unlock.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("rst.pre_busy", int'(busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("rst.number", int'(number), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.attempts", int'(attempts), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst.idle_after", int'(busy), 0);
    send_and_check("rst_clean", 1'b0);

    // Start pulses while busy are dropped.
    send_and_check("busy_start", 1'b1);

    // Randomized traffic against the reference model with a simple lock model.
    m_active = 1'b0; m_pos = 0; m_att = 1;
    cyc = 0; last_match = -100; p0 = 0; p1 = 0; p2 = 0; lock_on = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      bit st, ab, ul, eb, ed, ef;
      int en;
      if ($urandom_range(0, 63) == 0) lock_on = !lock_on;
      st = ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 39) == 0);
      ul = (lock_on && (cyc - last_match) >= 2 && (cyc - last_match) <= 4) ||
           ($urandom_range(0, 15) == 0);
      start = st; abort = ab; unlocked_in = ul;
      model_step(st, ab, ul, en, eb, ed, ef);
      tick();
      chk($sformatf("rand%0d.number", k), int'(number), en);
      chk($sformatf("rand%0d.busy", k), int'(busy), int'(eb));
      chk($sformatf("rand%0d.done", k), int'(done), int'(ed));
      chk($sformatf("rand%0d.fail", k), int'(fail), int'(ef));
      chk($sformatf("rand%0d.attempts", k), int'(attempts), m_att);
      cyc++;
      p2 = p1; p1 = p0; p0 = en;
      if (p2 == 1 && p1 == 3 && p0 == 5) last_match = cyc;
    end
    start = 1'b0; abort = 1'b0; unlocked_in = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
